weight_fetch_ctrl: RTL and testbench

//  Sequences the block-ROM weight store (registered read, 1-cycle latency, 9*`data_len-bit word =
//  one 3x3 kernel) for a conv layer. Walks filters x input-channel kernels, replays each filter
//  'reps' times, and streams words to the MAC array over valid/ready. Sits between rom and the PE.

---
 rtl/weight_fetch_ctrl_pkg.sv | 21 ++
 rtl/weight_fetch_ctrl_if.sv | 33 +++
 rtl/weight_fetch_ctrl_fifo.sv | 56 +++++
 rtl/weight_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared types and constants for the conv-layer weight fetch controller.
package weight_fetch_ctrl_pkg;

    localparam int DATA_LEN   = 8;
    localparam int KSIZE      = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int CREDITS    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Counter width for a 0..limit-1 range, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// ROM port and kernel-word stream between the fetch controller, weight ROM and MAC array.
interface weight_fetch_ctrl_if import weight_fetch_ctrl_pkg::*; #(
    parameter int dwidth = KSIZE * DATA_LEN,
    parameter int awidth = 8
);
    logic [awidth-1:0] rom_addr;
    logic [dwidth-1:0] rom_q;
    logic [dwidth-1:0] w_data;
    logic              w_valid;
    logic              w_ready;
    logic              w_last_k;
    logic              w_last;

    modport master (
        output rom_addr,
        input  rom_q,
        output w_data,
        output w_valid,
        output w_last_k,
        output w_last,
        input  w_ready
    );

    modport slave (
        input  rom_addr,
        output rom_q,
        input  w_data,
        input  w_valid,
        input  w_last_k,
        input  w_last,
        output w_ready
    );
endinterface

// File: rtl/weight_fetch_ctrl_fifo.sv
// Four-entry first-word-fall-through FIFO holding kernel words with their last_k/last tags.
module weight_fetch_ctrl_fifo import weight_fetch_ctrl_pkg::*; #(
    parameter int width = 74
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [width-1:0]                wr_data,
    input  logic                            rd_en,
    output logic [width-1:0]                rd_data,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

    logic [width-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt_q;
    logic             do_wr;
    logic             do_rd;

    assign do_rd   = rd_en && (cnt_q != '0);
    assign do_wr   = wr_en && ((cnt_q != FULL) || do_rd);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Walks filters x kernels of a conv layer through the weight ROM, replaying each filter
// 'reps' times, and streams the 3x3 kernel words to the MAC array over valid/ready.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for start; counters hold, rom_addr holds
//  ST_RUN   | issuing ROM reads while FIFO credit is available
//  ST_DRAIN | all addresses issued; waiting for the w_last transfer
//  ST_DONE  | one-cycle done pulse, then back to idle
module weight_fetch_ctrl import weight_fetch_ctrl_pkg::*; #(
    parameter int dwidth = KSIZE * DATA_LEN,
    parameter int awidth = 8,
    parameter int n_out  = 32,
    parameter int n_in   = 5,
    parameter int reps   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    weight_fetch_ctrl_if.master bus,
    output logic                busy,
    output logic                done
);
    localparam int KW = cnt_width(n_in);
    localparam int RW = cnt_width(reps);
    localparam int FW = cnt_width(n_out);
    localparam int EW = dwidth + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [KW-1:0]     K_LAST    = KW'(n_in - 1);
    localparam logic [RW-1:0]     R_LAST    = RW'(reps - 1);
    localparam logic [FW-1:0]     F_LAST    = FW'(n_out - 1);
    localparam logic [awidth-1:0] BASE_STEP = awidth'(n_in);
    localparam logic [CW:0]       CRED_LIM  = (CW + 1)'(CREDITS);

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q;
    logic [RW-1:0]     r_q;
    logic [FW-1:0]     f_q;
    logic [awidth-1:0] base_q;
    logic [awidth-1:0] addr_hold_q;
    logic [awidth-1:0] cur_addr;
    logic              pipe_v_q;
    logic              pipe_lk_q;
    logic              pipe_last_q;
    logic              issue;
    logic              tag_lk;
    logic              tag_last;
    logic              xfer;
    logic [CW-1:0]     occ;
    logic              fifo_empty;
    logic [EW-1:0]     fifo_rd;

    assign tag_lk   = (k_q == K_LAST);
    assign tag_last = tag_lk && (r_q == R_LAST) && (f_q == F_LAST);
    assign cur_addr = base_q + awidth'(k_q);

    // Credit covers words already buffered plus the read still in the ROM pipe.
    assign issue = (state_q == ST_RUN) &&
                   (({1'b0, occ} + {{CW{1'b0}}, pipe_v_q}) < CRED_LIM);

    assign bus.rom_addr = issue ? cur_addr : addr_hold_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (issue && tag_last) state_d = ST_DRAIN;
            ST_DRAIN: if (xfer && bus.w_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // k fastest, then r, then f; counters freeze on the final issue so rom_addr holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q         <= '0;
            r_q         <= '0;
            f_q         <= '0;
            base_q      <= '0;
            addr_hold_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            k_q    <= '0;
            r_q    <= '0;
            f_q    <= '0;
            base_q <= '0;
        end else if (issue) begin
            addr_hold_q <= cur_addr;
            if (!tag_lk) begin
                k_q <= k_q + 1'b1;
            end else if (!tag_last) begin
                k_q <= '0;
                if (r_q != R_LAST) begin
                    r_q <= r_q + 1'b1;
                end else begin
                    r_q    <= '0;
                    f_q    <= f_q + 1'b1;
                    base_q <= base_q + BASE_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v_q    <= 1'b0;
            pipe_lk_q   <= 1'b0;
            pipe_last_q <= 1'b0;
        end else begin
            pipe_v_q    <= issue;
            pipe_lk_q   <= tag_lk;
            pipe_last_q <= tag_last;
        end
    end

    weight_fetch_ctrl_fifo #(
        .width (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pipe_v_q),
        .wr_data ({pipe_last_q, pipe_lk_q, bus.rom_q}),
        .rd_en   (xfer),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .count   (occ)
    );

    assign xfer         = bus.w_valid && bus.w_ready;
    assign bus.w_valid  = !fifo_empty;
    assign bus.w_data   = fifo_rd[dwidth-1:0];
    // Storage is not reset, so tags are qualified to read as zero when nothing is held.
    assign bus.w_last_k = !fifo_empty && fifo_rd[dwidth];
    assign bus.w_last   = !fifo_empty && fifo_rd[dwidth+1];

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: three parameterisations, cycle-exact checks plus a scoreboard.
module tb_weight_fetch_ctrl;

    localparam int DW = 72;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_s;
    logic [2:0]  busy_o, done_o, wv_o, wl_o;
    logic [7:0]  addr_o  [3];
    logic [71:0] wdata_o [3];
    int          nw_o    [3];
    int          dcnt_o  [3];
    int          mode    [3];
    int          cyc = 0;
    int          t0 = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Word w of the stream: filter w/(ni*rp), kernel w%ni; ROM holds mem[i]=i.
    function automatic int exp_addr(input int w, input int ni, input int rp);
        return (w / (ni * rp)) * ni + (w % ni);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int NO = (g == 0) ? 2 : (g == 1) ? 32 : 1;
        localparam int NI = (g == 0) ? 3 : (g == 1) ? 5  : 1;
        localparam int RP = (g == 0) ? 2 : (g == 1) ? 1  : 3;
        localparam int TOTAL = NO * NI * RP;

        weight_fetch_ctrl_if #(.dwidth(DW), .awidth(8)) bus ();
        logic busy, done;
        int   nw, dcnt, last_cyc;
        bit   hv;
        logic [74:0] held;

        weight_fetch_ctrl #(
            .dwidth(DW), .awidth(8), .n_out(NO), .n_in(NI), .reps(RP)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_s[g]),
            .bus   (bus),
            .busy  (busy),
            .done  (done)
        );

        always @(posedge clk) bus.rom_q <= DW'(bus.rom_addr);

        assign busy_o[g]  = busy;
        assign done_o[g]  = done;
        assign wv_o[g]    = bus.w_valid;
        assign wl_o[g]    = bus.w_last;
        assign addr_o[g]  = bus.rom_addr;
        assign wdata_o[g] = bus.w_data;
        assign nw_o[g]    = nw;
        assign dcnt_o[g]  = dcnt;

        initial begin
            int rc;
            bus.w_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                rc = cyc - t0;
                case (mode[g])
                    1:       bus.w_ready = ($urandom_range(0, 9) >= 3);
                    2:       bus.w_ready = !(rc >= 5 && rc <= 14);
                    default: bus.w_ready = 1'b1;
                endcase
            end
        end

        initial begin
            nw = 0; dcnt = 0; last_cyc = -100; hv = 1'b0; held = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    nw = 0;
                    hv = 1'b0;
                end else begin
                    if (hv)
                        chk("hold", 80'({bus.w_valid, bus.w_last, bus.w_last_k, bus.w_data}), 80'(held));
                    if (bus.w_valid && bus.w_ready) begin
                        chk("overrun", 80'(nw < TOTAL), 80'(1));
                        chk("data", 80'(bus.w_data), 80'(exp_addr(nw, NI, RP)));
                        chk("last_k", 80'(bus.w_last_k), 80'((nw % NI) == NI - 1));
                        chk("last", 80'(bus.w_last), 80'(nw == TOTAL - 1));
                        if (bus.w_last) last_cyc = cyc;
                        nw++;
                        hv = 1'b0;
                    end else if (bus.w_valid) begin
                        hv = 1'b1;
                        held = {bus.w_valid, bus.w_last, bus.w_last_k, bus.w_data};
                    end else begin
                        hv = 1'b0;
                    end
                    if (done) begin
                        chk("done_lat", 80'(cyc), 80'(last_cyc + 1));
                        dcnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            chk("rst_valid", 80'(wv_o[g]), 80'(0));
            chk("rst_busy", 80'(busy_o[g]), 80'(0));
            chk("rst_done", 80'(done_o[g]), 80'(0));
            chk("rst_last", 80'(wl_o[g]), 80'(0));
            chk("rst_addr", 80'(addr_o[g]), 80'(0));
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse(input int g);
        start_s[g] = 1'b1;
        t0 = cyc;
        tick();
        start_s[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done_o[g]) seen = 1'b1;
        end
        chk("done_seen", 80'(seen), 80'(1));
        tick();
    endtask

    task automatic run_a(input bit extra);
        pulse(0);
        for (int rc = 1; rc <= 17; rc++) begin
            start_s[0] = extra && (rc == 4 || rc == 10);
            chk("t1_busy", 80'(busy_o[0]), 80'(rc <= 15));
            chk("t1_done", 80'(done_o[0]), 80'(rc == 15));
            chk("t1_valid", 80'(wv_o[0]), 80'(rc >= 3 && rc <= 14));
            if (rc <= 12) chk("t1_addr", 80'(addr_o[0]), 80'(exp_addr(rc - 1, 3, 2)));
            if (rc == 14) chk("t1_wlast", 80'(wl_o[0]), 80'(1));
            tick();
        end
        start_s[0] = 1'b0;
        chk("t1_words", 80'(nw_o[0]), 80'(12));
    endtask

    initial begin
        int d0;
        rst_n   = 1'b0;
        start_s = '0;
        mode    = '{0, 0, 0};

        do_reset();
        run_a(1'b0);
        do_reset();
        run_a(1'b1);

        // Backpressure window: issue stalls with four words outstanding.
        do_reset();
        mode[0] = 2;
        pulse(0);
        repeat (11) tick();
        chk("t2_valid", 80'(wv_o[0]), 80'(1));
        chk("t2_data", 80'(wdata_o[0]), 80'(2));
        chk("t2_addr", 80'(addr_o[0]), 80'(2));
        wait_done(0, 100);
        chk("t2_words", 80'(nw_o[0]), 80'(12));
        mode[0] = 0;

        // Reset in the middle of a pass, then restart from address 0.
        do_reset();
        pulse(0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t4_valid", 80'(wv_o[0]), 80'(0));
        chk("t4_busy", 80'(busy_o[0]), 80'(0));
        chk("t4_addr", 80'(addr_o[0]), 80'(0));
        chk("t4_done", 80'(done_o[0]), 80'(0));
        tick();
        tick();
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        chk("t4_busy2", 80'(busy_o[0]), 80'(1));
        tick();
        chk("t4_valid11", 80'(wv_o[0]), 80'(0));
        tick();
        chk("t4_valid12", 80'(wv_o[0]), 80'(1));
        chk("t4_data12", 80'(wdata_o[0]), 80'(0));
        wait_done(0, 100);
        chk("t4_words", 80'(nw_o[0]), 80'(12));

        mode[1] = 1;
        for (int s = 0; s < 3; s++) begin
            do_reset();
            d0 = dcnt_o[1];
            pulse(1);
            wait_done(1, 1500);
            repeat (3) tick();
            chk("t5_words", 80'(nw_o[1]), 80'(160));
            chk("t5_done_once", 80'(dcnt_o[1] - d0), 80'(1));
        end
        mode[1] = 0;

        do_reset();
        d0 = dcnt_o[2];
        pulse(2);
        wait_done(2, 50);
        repeat (3) tick();
        chk("t6_words", 80'(nw_o[2]), 80'(3));
        chk("t6_done_once", 80'(dcnt_o[2] - d0), 80'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
